gfx_frag_mask: RTL and testbench

Fragment coverage-mask store that sits directly downstream of the clear/mask-write stage and serves the fragment stage's mask queries. It holds one bit per linear pixel, packed into WORD_BITS-wide RAM words. Single-bit writes are applied with a pipelined read-modify-write, and point queries are answered through a read port with write-to-read forwarding. Write traffic is never stalled; queries yield to writes.

---
 rtl/gfx_frag_mask.sv | 233 +++++++++++++++++++++++
 tb/tb_gfx_frag_mask.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_frag_mask.sv
// gfx_frag_mask
// -----------------------------------------------------------------------------
// Fragment coverage-mask store: one bit per linear pixel, packed into
// WORD_BITS-wide RAM words. Single-bit writes from the clear/mask-write stage
// are applied by a two-stage read-modify-write (W0: RAM read, W1: merge and
// write). Point queries from the fragment stage share the RAM read port and
// are answered with forwarding from a last-written-word register, so a query
// always sees every write accepted before it.
//
// Ports
//   clk                   clock
//   rst_n                 asynchronous active-low reset
//   frag_mask_write       write strobe, never back-pressured
//   frag_mask_set         value written to the addressed bit
//   frag_mask_write_addr  linear pixel address of the write
//   query_valid           query request for the bit at query_addr
//   query_addr            linear pixel address of the query
//   query_ready           query accepted when query_valid && query_ready
//   result_valid          one-cycle pulse, result_mask valid
//   result_mask           stored bit for the accepted query
//   busy                  a write occupies W0 or W1
//
// Configuration macros
//   GFX_LINEAR_RES          number of linear pixels (default 1024 if unset)
//   GFX_MASK_RESULT_REG_EN  adds an output register on result_valid and
//                           result_mask (query latency 2 instead of 1)
// -----------------------------------------------------------------------------
`ifndef GFX_LINEAR_RES
`define GFX_LINEAR_RES 1024
`endif

module gfx_frag_mask #(
  parameter int WORD_BITS = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frag_mask_write,
  input  logic                                 frag_mask_set,
  input  logic [$clog2(`GFX_LINEAR_RES)-1:0]   frag_mask_write_addr,
  input  logic                                 query_valid,
  input  logic [$clog2(`GFX_LINEAR_RES)-1:0]   query_addr,
  output logic                                 query_ready,
  output logic                                 result_valid,
  output logic                                 result_mask,
  output logic                                 busy
);

  localparam int AW    = $clog2(`GFX_LINEAR_RES);
  localparam int BW    = $clog2(WORD_BITS);
  localparam int WW    = AW - BW;
  localparam int DEPTH = `GFX_LINEAR_RES / WORD_BITS;

  // Storage (not reset) and its registered read data
  logic [WORD_BITS-1:0] mem_q [DEPTH];
  logic [WORD_BITS-1:0] ram_rdata_q;

  // Address split and read-port arbitration
  logic [WW-1:0]        wr_word_s;
  logic [BW-1:0]        wr_bit_s;
  logic [WW-1:0]        qa_word_s;
  logic [BW-1:0]        qa_bit_s;
  logic [WW-1:0]        rd_word_s;
  logic                 q_accept_s;

  // W1 stage (write accepted last cycle)
  logic                 w1_valid_q, w1_valid_d;
  logic [WW-1:0]        w1_word_q,  w1_word_d;
  logic [BW-1:0]        w1_bit_q,   w1_bit_d;
  logic                 w1_set_q,   w1_set_d;
  logic                 w1_fwd_s;
  logic [WORD_BITS-1:0] w1_old_s;
  logic [WORD_BITS-1:0] w1_sel_s;
  logic [WORD_BITS-1:0] w1_new_s;

  // Last-written word, used to forward data the RAM cannot yet return
  logic                 lw_valid_q, lw_valid_d;
  logic [WW-1:0]        lw_word_q,  lw_word_d;
  logic [WORD_BITS-1:0] lw_data_q,  lw_data_d;

  // Query stage (query accepted last cycle)
  logic                 q_valid_q, q_valid_d;
  logic [WW-1:0]        q_word_q,  q_word_d;
  logic [BW-1:0]        q_bit_q,   q_bit_d;
  logic                 q_fwd_s;
  logic [WORD_BITS-1:0] q_data_s;
  logic                 q_bit_val_s;

  assign wr_word_s  = frag_mask_write_addr[AW-1:BW];
  assign wr_bit_s   = frag_mask_write_addr[BW-1:0];
  assign qa_word_s  = query_addr[AW-1:BW];
  assign qa_bit_s   = query_addr[BW-1:0];

  // Writes own the read port whenever they are present.
  assign query_ready = ~frag_mask_write;
  assign q_accept_s  = query_valid & ~frag_mask_write;
  assign busy        = frag_mask_write | w1_valid_q;

  // Read-port address: the write's word in W0, otherwise the query's word
  always_comb begin
    rd_word_s = qa_word_s;
    if (frag_mask_write) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = qa_word_s;
    end
  end

  // W1 merge: forward from lw when the RAM read was issued before the
  // previous write to this word landed, then replace the addressed bit
  always_comb begin
    w1_fwd_s = lw_valid_q && (lw_word_q == w1_word_q);
    w1_old_s = w1_fwd_s ? lw_data_q : ram_rdata_q;
    w1_sel_s = {{(WORD_BITS-1){1'b0}}, 1'b1} << w1_bit_q;
    if (w1_set_q) begin
      w1_new_s = w1_old_s | w1_sel_s;
    end else begin
      w1_new_s = w1_old_s & ~w1_sel_s;
    end
  end

  // Query result select: lw holds every write that the RAM read missed
  always_comb begin
    q_fwd_s     = lw_valid_q && (lw_word_q == q_word_q);
    q_data_s    = q_fwd_s ? lw_data_q : ram_rdata_q;
    q_bit_val_s = q_data_s[q_bit_q];
  end

  // Next-state for the write pipeline, lw register and query stage
  always_comb begin
    w1_valid_d = frag_mask_write;
    w1_word_d  = w1_word_q;
    w1_bit_d   = w1_bit_q;
    w1_set_d   = w1_set_q;
    if (frag_mask_write) begin
      w1_word_d = wr_word_s;
      w1_bit_d  = wr_bit_s;
      w1_set_d  = frag_mask_set;
    end else begin
      w1_word_d = w1_word_q;
      w1_bit_d  = w1_bit_q;
      w1_set_d  = w1_set_q;
    end

    lw_valid_d = lw_valid_q;
    lw_word_d  = lw_word_q;
    lw_data_d  = lw_data_q;
    if (w1_valid_q) begin
      lw_valid_d = 1'b1;
      lw_word_d  = w1_word_q;
      lw_data_d  = w1_new_s;
    end else begin
      lw_valid_d = lw_valid_q;
      lw_word_d  = lw_word_q;
      lw_data_d  = lw_data_q;
    end

    q_valid_d = q_accept_s;
    q_word_d  = q_word_q;
    q_bit_d   = q_bit_q;
    if (q_accept_s) begin
      q_word_d = qa_word_s;
      q_bit_d  = qa_bit_s;
    end else begin
      q_word_d = q_word_q;
      q_bit_d  = q_bit_q;
    end
  end

  // Pipeline, lw and query-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1_valid_q  <= 1'b0;
      w1_word_q   <= {WW{1'b0}};
      w1_bit_q    <= {BW{1'b0}};
      w1_set_q    <= 1'b0;
      lw_valid_q  <= 1'b0;
      lw_word_q   <= {WW{1'b0}};
      lw_data_q   <= {WORD_BITS{1'b0}};
      q_valid_q   <= 1'b0;
      q_word_q    <= {WW{1'b0}};
      q_bit_q     <= {BW{1'b0}};
      ram_rdata_q <= {WORD_BITS{1'b0}};
    end else begin
      w1_valid_q  <= w1_valid_d;
      w1_word_q   <= w1_word_d;
      w1_bit_q    <= w1_bit_d;
      w1_set_q    <= w1_set_d;
      lw_valid_q  <= lw_valid_d;
      lw_word_q   <= lw_word_d;
      lw_data_q   <= lw_data_d;
      q_valid_q   <= q_valid_d;
      q_word_q    <= q_word_d;
      q_bit_q     <= q_bit_d;
      ram_rdata_q <= mem_q[rd_word_s];
    end
  end

  // RAM write port; reset clears w1_valid_q so an in-flight write is dropped
  always_ff @(posedge clk) begin
    if (w1_valid_q) begin
      mem_q[w1_word_q] <= w1_new_s;
    end
  end

`ifdef GFX_MASK_RESULT_REG_EN
  logic res_valid_q, res_valid_d;
  logic res_mask_q,  res_mask_d;

  // Output register stage: forwarding already resolved in the cycle before
  always_comb begin
    res_valid_d = q_valid_q;
    res_mask_d  = q_valid_q & q_bit_val_s;
  end

  // Registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_mask_q  <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_mask_q  <= res_mask_d;
    end
  end

  assign result_valid = res_valid_q;
  assign result_mask  = res_mask_q;
`else
  assign result_valid = q_valid_q;
  assign result_mask  = q_valid_q & q_bit_val_s;
`endif

endmodule

// File: tb/tb_gfx_frag_mask.sv
`timescale 1ns/1ps
`ifndef GFX_LINEAR_RES
`define GFX_LINEAR_RES 1024
`endif

module tb_gfx_frag_mask;

  localparam int RES = `GFX_LINEAR_RES;
  localparam int AW  = $clog2(RES);
`ifdef GFX_MASK_RESULT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frag_mask_write = 1'b0;
  logic          frag_mask_set = 1'b0;
  logic [AW-1:0] frag_mask_write_addr = '0;
  logic          query_valid = 1'b0;
  logic [AW-1:0] query_addr = '0;
  logic          query_ready, result_valid, result_mask, busy;

  always #5 clk = ~clk;

  gfx_frag_mask #(.WORD_BITS(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .frag_mask_write      (frag_mask_write),
    .frag_mask_set        (frag_mask_set),
    .frag_mask_write_addr (frag_mask_write_addr),
    .query_valid          (query_valid),
    .query_addr           (query_addr),
    .query_ready          (query_ready),
    .result_valid         (result_valid),
    .result_mask          (result_mask),
    .busy                 (busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference: one bit per pixel, updated the moment a write is accepted.
  bit ref_mem [RES];
  typedef struct { int cyc; bit val; } pend_t;
  pend_t pend[$];
  bit    got[$];
  int    cyc = 0;
  bit    prev_w = 1'b0;

  logic o_rdy, o_busy, o_rv, o_rm;
  logic e_rdy, e_busy, e_rv, e_rm;

  // One clock cycle of stimulus; records observed and reference values.
  task automatic step(input bit w, input bit s, input int wa, input bit qv, input int qa);
    frag_mask_write      = w;
    frag_mask_set        = s;
    frag_mask_write_addr = AW'(wa);
    query_valid          = qv;
    query_addr           = AW'(qa);
    #1;
    o_rdy  = query_ready;
    o_busy = busy;
    e_rdy  = !w;
    e_busy = w || prev_w;
    if (qv && !w) pend.push_back('{cyc, ref_mem[qa]});
    if (w) ref_mem[wa] = s;
    prev_w = w;
    @(posedge clk);
    cyc++;
    #1;
    o_rv = result_valid;
    o_rm = result_mask;
    e_rv = 1'b0;
    e_rm = 1'b0;
    if (pend.size() > 0 && pend[0].cyc + LAT == cyc) begin
      e_rv = 1'b1;
      e_rm = pend[0].val;
      void'(pend.pop_front());
    end
    if (o_rv === 1'b1) got.push_back(o_rm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frag_mask_write = 1'b0;
    query_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (query_ready !== 1'b1) begin failures++; $display("FAIL reset_query_ready got=%b exp=1", query_ready); end
    frag_mask_write = 1'b1;
    #1;
    checks++;
    if (query_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_ungated got=%b exp=0", query_ready); end
    frag_mask_write = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL post_reset_result_valid got=%b exp=0", result_valid); end
  endtask

  task automatic test_clear_sweep();
    for (int a = 0; a < RES; a++) begin
      step(1'b1, 1'b0, a, 1'b1, 37);
      checks += 3;
      if (o_rdy !== e_rdy) begin failures++; $display("FAIL clear_ready a=%0d got=%b exp=%b", a, o_rdy, e_rdy); end
      if (o_busy !== e_busy) begin failures++; $display("FAIL clear_busy a=%0d got=%b exp=%b", a, o_busy, e_busy); end
      if (o_rv !== e_rv) begin failures++; $display("FAIL clear_rvalid a=%0d got=%b exp=%b", a, o_rv, e_rv); end
    end
    // The held query at 37 is accepted the cycle the sweep ends.
    got.delete();
    for (int i = 0; i < 4 + LAT; i++) begin
      int qa;
      qa = (i == 0) ? 37 : (i == 1) ? 0 : (i == 2) ? RES - 1 : 0;
      step(1'b0, 1'b0, 0, (i < 3), qa);
      checks += 3;
      if (o_rdy !== e_rdy) begin failures++; $display("FAIL clear_q_ready got=%b exp=%b", o_rdy, e_rdy); end
      if (o_busy !== e_busy) begin failures++; $display("FAIL clear_q_busy got=%b exp=%b", o_busy, e_busy); end
      if (o_rv !== e_rv) begin failures++; $display("FAIL clear_q_rvalid i=%0d got=%b exp=%b", i, o_rv, e_rv); end
      if (e_rv) begin checks++; if (o_rm !== e_rm) begin failures++; $display("FAIL clear_q_mask got=%b exp=%b", o_rm, e_rm); end end
    end
    checks++;
    if (got.size() != 3) begin failures++; $display("FAIL clear_result_count got=%0d exp=3", got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 1'b0) begin failures++; $display("FAIL clear_value idx=%0d got=%b exp=0", i, got[i]); end
      end
    end
  endtask

  task automatic test_same_word();
    bit exp_v [4];
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b0};
    got.delete();
    for (int i = 0; i < 7 + LAT; i++) begin
      if (i < 3) step(1'b1, 1'b1, 64 + i, 1'b0, 0);
      else       step(1'b0, 1'b0, 0, (i < 7), 64 + i - 3);
      checks += 3;
      if (o_rdy !== e_rdy) begin failures++; $display("FAIL same_word_ready i=%0d got=%b exp=%b", i, o_rdy, e_rdy); end
      if (o_busy !== e_busy) begin failures++; $display("FAIL same_word_busy i=%0d got=%b exp=%b", i, o_busy, e_busy); end
      if (o_rv !== e_rv) begin failures++; $display("FAIL same_word_rvalid i=%0d got=%b exp=%b", i, o_rv, e_rv); end
      if (e_rv) begin checks++; if (o_rm !== e_rm) begin failures++; $display("FAIL same_word_mask i=%0d got=%b exp=%b", i, o_rm, e_rm); end end
    end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL same_word_count got=%0d exp=4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp_v[i]) begin failures++; $display("FAIL same_word_value addr=%0d got=%b exp=%b", 64 + i, got[i], exp_v[i]); end
      end
    end
  endtask

  task automatic test_write_then_query();
    got.delete();
    for (int i = 0; i < 3 + LAT; i++) begin
      if (i == 0) step(1'b1, 1'b1, 5, 1'b0, 0);
      else        step(1'b0, 1'b0, 0, (i == 1), 5);
      checks += 3;
      if (o_rdy !== e_rdy) begin failures++; $display("FAIL wtq_ready i=%0d got=%b exp=%b", i, o_rdy, e_rdy); end
      if (o_busy !== e_busy) begin failures++; $display("FAIL wtq_busy i=%0d got=%b exp=%b", i, o_busy, e_busy); end
      if (o_rv !== e_rv) begin failures++; $display("FAIL wtq_rvalid i=%0d got=%b exp=%b", i, o_rv, e_rv); end
      if (e_rv) begin checks++; if (o_rm !== e_rm) begin failures++; $display("FAIL wtq_mask got=%b exp=%b", o_rm, e_rm); end end
    end
    checks++;
    if (got.size() != 1 || got[0] !== 1'b1) begin failures++; $display("FAIL wtq_value count=%0d exp one result of 1", got.size()); end
  endtask

  task automatic test_collision();
    got.delete();
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i == 0)      step(1'b1, 1'b1, 300, 1'b1, 300);
      else if (i == 1) step(1'b1, 1'b0, 301, 1'b1, 300);
      else             step(1'b0, 1'b0, 0, (i == 2), 300);
      checks += 3;
      if (o_rdy !== e_rdy) begin failures++; $display("FAIL coll_ready i=%0d got=%b exp=%b", i, o_rdy, e_rdy); end
      if (o_busy !== e_busy) begin failures++; $display("FAIL coll_busy i=%0d got=%b exp=%b", i, o_busy, e_busy); end
      if (o_rv !== e_rv) begin failures++; $display("FAIL coll_rvalid i=%0d got=%b exp=%b", i, o_rv, e_rv); end
      if (e_rv) begin checks++; if (o_rm !== e_rm) begin failures++; $display("FAIL coll_mask got=%b exp=%b", o_rm, e_rm); end end
    end
    checks++;
    if (got.size() != 1 || got[0] !== 1'b1) begin failures++; $display("FAIL coll_value count=%0d exp one result of 1", got.size()); end
  endtask

  task automatic test_overwrite();
    got.delete();
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 2) step(1'b1, (i == 0), 100, 1'b0, 0);
      else       step(1'b0, 1'b0, 0, (i < 4), 98 + i);
      checks += 3;
      if (o_rdy !== e_rdy) begin failures++; $display("FAIL ovw_ready i=%0d got=%b exp=%b", i, o_rdy, e_rdy); end
      if (o_busy !== e_busy) begin failures++; $display("FAIL ovw_busy i=%0d got=%b exp=%b", i, o_busy, e_busy); end
      if (o_rv !== e_rv) begin failures++; $display("FAIL ovw_rvalid i=%0d got=%b exp=%b", i, o_rv, e_rv); end
      if (e_rv) begin checks++; if (o_rm !== e_rm) begin failures++; $display("FAIL ovw_mask i=%0d got=%b exp=%b", i, o_rm, e_rm); end end
    end
    checks++;
    if (got.size() != 2 || got[0] !== 1'b0 || got[1] !== 1'b0) begin
      failures++; $display("FAIL ovw_value count=%0d exp two results of 0", got.size());
    end
  endtask

  task automatic test_reset_mid_write();
    bit old_v;
    old_v = ref_mem[200];
    step(1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 200, 1'b1, 0);
    // Now inside W1 of the write to 200.
    rst_n = 1'b0;
    frag_mask_write = 1'b0;
    query_valid = 1'b0;
    ref_mem[200] = old_v;
    pend.delete();
    prev_w = 1'b0;
    #1;
    checks += 2;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_rvalid got=%b exp=0", result_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks += 2;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL rst_after_rvalid got=%b exp=0", result_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_after_busy got=%b exp=0", busy); end
    got.delete();
    for (int i = 0; i < 2 + LAT; i++) begin
      step(1'b0, 1'b0, 0, (i == 0), 200);
      checks += 3;
      if (o_rdy !== e_rdy) begin failures++; $display("FAIL rst_q_ready got=%b exp=%b", o_rdy, e_rdy); end
      if (o_busy !== e_busy) begin failures++; $display("FAIL rst_q_busy got=%b exp=%b", o_busy, e_busy); end
      if (o_rv !== e_rv) begin failures++; $display("FAIL rst_q_rvalid i=%0d got=%b exp=%b", i, o_rv, e_rv); end
      if (e_rv) begin checks++; if (o_rm !== e_rm) begin failures++; $display("FAIL rst_q_mask got=%b exp=%b", o_rm, e_rm); end end
    end
    checks++;
    if (got.size() != 1 || got[0] !== old_v) begin failures++; $display("FAIL rst_pre_write_value count=%0d exp=%b", got.size(), old_v); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800 + LAT; i++) begin
      bit w, s, qv;
      int wa, qa;
      w  = (i < 800) && ($urandom_range(0, 9) < 4);
      s  = $urandom_range(0, 1);
      wa = $urandom_range(0, 95);
      qv = (i < 800) && ($urandom_range(0, 1) == 1);
      qa = $urandom_range(0, 95);
      step(w, s, wa, qv, qa);
      checks += 3;
      if (o_rdy !== e_rdy) begin failures++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, o_rdy, e_rdy); end
      if (o_busy !== e_busy) begin failures++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, o_busy, e_busy); end
      if (o_rv !== e_rv) begin failures++; $display("FAIL rand_rvalid i=%0d got=%b exp=%b", i, o_rv, e_rv); end
      if (e_rv) begin checks++; if (o_rm !== e_rm) begin failures++; $display("FAIL rand_mask i=%0d got=%b exp=%b", i, o_rm, e_rm); end end
    end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_same_word();
    test_write_then_query();
    test_collision();
    test_overwrite();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
